// File: rtl/round_data_select.sv
// round_data_select: picks one WIDTH-bit lane out of N_IN packed lanes and
// delivers it through a registered output stage backed by one skid register.
// Out-of-range selects produce an all-zero beat and raise a sticky error flag.
module round_data_select #(
  parameter int WIDTH = 128,
  parameter int N_IN  = 3,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  input  logic                  err_clr,
  output logic [15:0]           beat_cnt
);

  // Occupancy of the OUT/SKID pair: EMPTY, OUT only, OUT and SKID.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] sel_val;
  logic             sel_oor;
  logic             accept;
  logic             pop;
  logic             load_out_in;
  logic             load_out_skid;
  logic             load_skid;

  assign sel_oor   = (int'(sel) >= N_IN);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid && out_ready;

  // Lane multiplexer; an index past the last lane falls through to zero.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(sel) == i) begin
        sel_val = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next occupancy state and which storage stage gets loaded this cycle.
  always_comb begin
    state_next    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_out_in = 1'b1;
          state_next  = ONE;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          load_out_skid = 1'b1;
          state_next    = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register; in_ready is registered from the state we are entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != TWO);
    end
  end

  // Payload registers: OUT is the only source of out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (load_out_in) begin
        out_data <= sel_val;
      end else if (load_out_skid) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= sel_val;
      end
    end
  end

  // Sticky select error (set beats clear) and wrapping handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err  <= 1'b0;
      beat_cnt <= 16'd0;
    end else begin
      if (accept && sel_oor) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end
      if (pop) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_round_data_select.sv
// Testbench for round_data_select: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_round_data_select;

  localparam int WIDTH = 128;
  localparam int N_IN  = 3;
  localparam int SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N_IN*WIDTH-1:0] in_data = '0;
  logic [SEL_W-1:0]      sel = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  sel_err;
  logic                  err_clr = 1'b0;
  logic [15:0]           beat_cnt;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: beats accepted but not yet delivered, in order.
  logic [WIDTH-1:0] m_q[$];
  logic             m_rdy = 1'b0;
  logic             m_err = 1'b0;
  logic [15:0]      m_cnt = 16'd0;

  round_data_select #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
    .err_clr(err_clr), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] pickLane(input logic [N_IN*WIDTH-1:0] d,
                                                input logic [SEL_W-1:0] s);
    int idx;
    idx = int'(s);
    if (idx < N_IN) return d[idx*WIDTH +: WIDTH];
    return '0;
  endfunction

  task automatic cmp(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a two-entry FIFO seen purely as a queue of beats.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rdy = 1'b0;
      m_err = 1'b0;
      m_cnt = 16'd0;
    end else begin
      logic acc;
      acc = in_valid && m_rdy;
      if (m_q.size() > 0 && out_ready) begin
        void'(m_q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (acc) m_q.push_back(pickLane(in_data, sel));
      if (acc && int'(sel) >= N_IN) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_rdy = (m_q.size() < 2);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("out_valid", WIDTH'(out_valid), WIDTH'(m_q.size() > 0));
    cmp("in_ready", WIDTH'(in_ready), WIDTH'(m_rdy));
    cmp("sel_err", WIDTH'(sel_err), WIDTH'(m_err));
    cmp("beat_cnt", WIDTH'(beat_cnt), WIDTH'(m_cnt));
    if (m_q.size() > 0) cmp("out_data", out_data, m_q[0]);
  end

  task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] s,
                               input logic ordy, input logic clr);
    @(negedge clk);
    #1;
    in_valid  = v;
    sel       = s;
    out_ready = ordy;
    err_clr   = clr;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    cmp(name, act, exp);
  endtask

  task automatic setLanes123();
    in_data = '0;
    in_data[0*WIDTH +: WIDTH] = 128'd1;
    in_data[1*WIDTH +: WIDTH] = 128'd2;
    in_data[2*WIDTH +: WIDTH] = 128'd3;
  endtask

  task automatic randData();
    for (int w = 0; w < (N_IN*WIDTH)/32; w++) in_data[w*32 +: 32] = $urandom();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", WIDTH'(out_valid), '0);
    checkOutput("reset_in_ready", WIDTH'(in_ready), '0);
    checkOutput("reset_out_data", out_data, '0);
    checkOutput("reset_sel_err", WIDTH'(sel_err), '0);
    checkOutput("reset_beat_cnt", WIDTH'(beat_cnt), '0);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("ready_after_reset", WIDTH'(in_ready), WIDTH'(1));

    // Basic select of lane 1.
    setLanes123();
    applyStimulus(1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("basic_out_data", out_data, 128'd2);
    checkOutput("basic_out_valid", WIDTH'(out_valid), WIDTH'(1));
    applyStimulus(0, 0, 1, 0);
    checkOutput("basic_beat_cnt", WIDTH'(beat_cnt), WIDTH'(16'd1));

    // Out-of-range select, clear, and clear colliding with a new set.
    applyStimulus(1, 3, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("oor_out_data", out_data, '0);
    checkOutput("oor_sel_err", WIDTH'(sel_err), WIDTH'(1));
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("clr_sel_err", WIDTH'(sel_err), '0);
    applyStimulus(1, 3, 1, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("set_wins_sel_err", WIDTH'(sel_err), WIDTH'(1));

    // Stall: two beats fill OUT and SKID, third offer is held off.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 2, 0, 0);
    checkOutput("stall_in_ready", WIDTH'(in_ready), '0);
    checkOutput("stall_head", out_data, 128'd1);
    applyStimulus(1, 2, 0, 0);
    checkOutput("stall_hold", out_data, 128'd1);
    applyStimulus(1, 2, 1, 0);
    applyStimulus(1, 2, 1, 0);
    checkOutput("drain_lane1", out_data, 128'd2);
    applyStimulus(0, 0, 1, 0);
    checkOutput("drain_lane2", out_data, 128'd3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("drain_empty", WIDTH'(out_valid), '0);

    // Asynchronous reset while both stages are full.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", WIDTH'(out_valid), '0);
    checkOutput("rst_mid_beat_cnt", WIDTH'(beat_cnt), '0);
    checkOutput("rst_mid_sel_err", WIDTH'(sel_err), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) applyStimulus(0, 0, 1, 0);
    checkOutput("rst_no_stale", WIDTH'(out_valid), '0);

    // Randomised traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      randData();
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

    // Counter wrap: exactly 65,536 handshakes from a fresh reset.
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    setLanes123();
    for (int c = 0; c < 65536; c++) applyStimulus(1, 2, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrap_beat_cnt", WIDTH'(beat_cnt), '0);
    checkOutput("wrap_out_valid", WIDTH'(out_valid), '0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
